// File: rtl/res_join.sv
// res_join: joins a local vector stream with a remote merge-in stream into a 2-entry FIFO.
// merge_in=1 adds the streams element-wise with saturation; merge_in=0 passes local through.
`ifndef QW
`define QW 8
`endif
`ifndef XW
`define XW 4
`endif

module res_join #(
    parameter bit merge_in = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [`QW-1:0] data_i_local [`XW],
    input  logic           valid_i_local,
    output logic           ready_o_local,
    input  logic [`QW-1:0] data_i_mergein [`XW],
    input  logic           valid_i_mergein,
    output logic           ready_o_mergein,
    output logic [`QW-1:0] data_o [`XW],
    output logic           valid_o,
    input  logic           ready_i,
    output logic           sat_o,
    output logic [15:0]    beat_cnt_o
);
    localparam int QW = `QW;
    localparam int XW = `XW;

    logic [QW-1:0] mem [2][XW];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          full;
    logic          push;
    logic          pop;
    logic [QW:0]   sums [XW];
    logic [QW-1:0] joined [XW];
    logic          any_sat;

    assign full    = (count == 2'd2);
    assign valid_o = (count != 2'd0);
    assign pop     = valid_o & ready_i;

    // Readiness never looks at ready_i: a full FIFO simply refuses new beats.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ready_o_local   = 1'b0;
        ready_o_mergein = 1'b0;
        push            = 1'b0;
        if (!rst) begin
            if (merge_in) begin
                ready_o_local   = valid_i_mergein & ~full;
                ready_o_mergein = valid_i_local & ~full;
                push            = valid_i_local & valid_i_mergein & ~full;
            end else begin
                ready_o_local   = ~full;
                push            = valid_i_local & ~full;
            end
        end
    end

    // One guard bit is enough: overflow shows up as the top two sum bits disagreeing.
    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i < XW; i++) begin
            sums[i]   = {data_i_local[i][QW-1], data_i_local[i]}
                      + {data_i_mergein[i][QW-1], data_i_mergein[i]};
            joined[i] = data_i_local[i];
            if (merge_in) begin
                if (sums[i][QW] != sums[i][QW-1]) begin
                    joined[i] = sums[i][QW] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
                    any_sat   = 1'b1;
                end else begin
                    joined[i] = sums[i][QW-1:0];
                end
            end
        end
    end

    // NOTE: storage is deliberately not reset; valid_o masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < XW; i++) begin
                mem[wr_ptr][i] <= joined[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            sat_o      <= 1'b0;
            beat_cnt_o <= 16'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push && any_sat) sat_o <= 1'b1;
            if (pop) beat_cnt_o <= beat_cnt_o + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < XW; i++) begin
            data_o[i] = mem[rd_ptr][i];
        end
    end

endmodule

// File: tb/tb_res_join.sv
// tb_res_join: drives a merging and a pass-through res_join against a queue-based model,
// with directed scenarios pinned by literal expectations and a randomized soak.
`ifndef QW
`define QW 8
`endif
`ifndef XW
`define XW 4
`endif

module tb_res_join;
    localparam int QW   = `QW;
    localparam int XW   = `XW;
    localparam int VW   = QW * XW;
    localparam int MAXV = 2 ** (QW - 1) - 1;
    localparam int MINV = -(2 ** (QW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready_i = 1'b1;

    logic [QW-1:0] dl_m [XW];
    logic [QW-1:0] dm_m [XW];
    logic [QW-1:0] do_m [XW];
    logic vl_m = 1'b0, vm_m = 1'b0, rl_m, rm_m, vo_m, sat_m;
    logic [15:0] cnt_m;

    logic [QW-1:0] dl_p [XW];
    logic [QW-1:0] dm_p [XW];
    logic [QW-1:0] do_p [XW];
    logic vl_p = 1'b0, vm_p = 1'b0, rl_p, rm_p, vo_p, sat_p;
    logic [15:0] cnt_p;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    res_join #(.merge_in(1'b1)) dut_m (
        .clk(clk), .rst(rst),
        .data_i_local(dl_m), .valid_i_local(vl_m), .ready_o_local(rl_m),
        .data_i_mergein(dm_m), .valid_i_mergein(vm_m), .ready_o_mergein(rm_m),
        .data_o(do_m), .valid_o(vo_m), .ready_i(ready_i),
        .sat_o(sat_m), .beat_cnt_o(cnt_m)
    );

    res_join #(.merge_in(1'b0)) dut_p (
        .clk(clk), .rst(rst),
        .data_i_local(dl_p), .valid_i_local(vl_p), .ready_o_local(rl_p),
        .data_i_mergein(dm_p), .valid_i_mergein(vm_p), .ready_o_mergein(rm_p),
        .data_o(do_p), .valid_o(vo_p), .ready_i(ready_i),
        .sat_o(sat_p), .beat_cnt_o(cnt_p)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] pack(input logic [QW-1:0] v [XW]);
        logic [VW-1:0] r;
        for (int i = 0; i < XW; i++) r[i*QW +: QW] = v[i];
        return r;
    endfunction

    // Reference join: plain integer add and clamp.
    task automatic join_model(input logic [VW-1:0] l, input logic [VW-1:0] m, input bit merge,
                              output logic [VW-1:0] r, output bit s);
        int a, b, t;
        s = 1'b0;
        r = '0;
        for (int i = 0; i < XW; i++) begin
            a = $signed(l[i*QW +: QW]);
            b = $signed(m[i*QW +: QW]);
            t = merge ? a + b : a;
            if (t > MAXV) begin t = MAXV; s = 1'b1; end
            else if (t < MINV) begin t = MINV; s = 1'b1; end
            r[i*QW +: QW] = t[QW-1:0];
        end
    endtask

    logic [VW-1:0] q_m [$];
    logic [VW-1:0] q_p [$];
    bit            es_m, es_p;
    logic [15:0]   ec_m, ec_p;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m.delete(); q_p.delete();
            es_m = 1'b0; es_p = 1'b0;
            ec_m = 16'd0; ec_p = 16'd0;
        end else begin
            bit pu, po, s;
            logic [VW-1:0] r;
            po = (q_m.size() != 0) && ready_i;
            pu = vl_m && vm_m && (q_m.size() < 2);
            join_model(pack(dl_m), pack(dm_m), 1'b1, r, s);
            if (po) begin void'(q_m.pop_front()); ec_m = ec_m + 16'd1; end
            if (pu) begin q_m.push_back(r); if (s) es_m = 1'b1; end

            po = (q_p.size() != 0) && ready_i;
            pu = vl_p && (q_p.size() < 2);
            join_model(pack(dl_p), pack(dm_p), 1'b0, r, s);
            if (po) begin void'(q_p.pop_front()); ec_p = ec_p + 16'd1; end
            if (pu) begin q_p.push_back(r); if (s) es_p = 1'b1; end
        end
    end

    task automatic cmp_inst(input string t, input bit mg, input int qs, input logic [VW-1:0] head,
                            input bit es, input logic [15:0] ec, input logic vl, input logic vm,
                            input logic rl, input logic rm, input logic vo, input logic [VW-1:0] dat,
                            input logic sat, input logic [15:0] cnt);
        logic erl, erm;
        erl = !rst && (mg ? (vm && qs < 2) : (qs < 2));
        erm = !rst && mg && vl && (qs < 2);
        check({t, "_valid_o"}, 64'(vo), 64'(qs != 0));
        if (qs != 0) check({t, "_data_o"}, 64'(dat), 64'(head));
        check({t, "_ready_local"}, 64'(rl), 64'(erl));
        check({t, "_ready_mergein"}, 64'(rm), 64'(erm));
        check({t, "_sat_o"}, 64'(sat), 64'(es));
        check({t, "_beat_cnt"}, 64'(cnt), 64'(ec));
    endtask

    always @(negedge clk) begin
        cmp_inst("m", 1'b1, q_m.size(), (q_m.size() != 0) ? q_m[0] : '0, es_m, ec_m,
                 vl_m, vm_m, rl_m, rm_m, vo_m, pack(do_m), sat_m, cnt_m);
        cmp_inst("p", 1'b0, q_p.size(), (q_p.size() != 0) ? q_p[0] : '0, es_p, ec_p,
                 vl_p, vm_p, rl_p, rm_p, vo_p, pack(do_p), sat_p, cnt_p);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [VW-1:0] l, input logic [VW-1:0] m);
        for (int i = 0; i < XW; i++) begin
            dl_m[i] = l[i*QW +: QW];
            dm_m[i] = m[i*QW +: QW];
        end
    endtask

    task automatic set_p(input logic [VW-1:0] l, input logic [VW-1:0] m);
        for (int i = 0; i < XW; i++) begin
            dl_p[i] = l[i*QW +: QW];
            dm_p[i] = m[i*QW +: QW];
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[VW-1:0];
    endfunction

    initial begin
        set_m('0, '0);
        set_p('0, '0);
        step();
        step();
        check("reset_valid_m", 64'(vo_m), 64'd0);
        check("reset_ready_m", 64'(rl_m), 64'd0);
        check("reset_ready_p", 64'(rl_p), 64'd0);
        rst = 1'b0;
        step();

        // Saturating add: {10,-3,100,-128} + {5,3,50,-1}.
        set_m({8'hFF, 8'd50, 8'd3, 8'd5} == 32'h0 ? '0 : '0, '0);
        dl_m[0] = 8'd10;  dl_m[1] = 8'hFD; dl_m[2] = 8'd100; dl_m[3] = 8'h80;
        dm_m[0] = 8'd5;   dm_m[1] = 8'd3;  dm_m[2] = 8'd50;  dm_m[3] = 8'hFF;
        vl_m = 1'b1; vm_m = 1'b1; ready_i = 1'b1;
        step();
        vl_m = 1'b0; vm_m = 1'b0;
        check("sat_add_valid", 64'(vo_m), 64'd1);
        check("sat_add_e0", 64'(do_m[0]), 64'h0F);
        check("sat_add_e1", 64'(do_m[1]), 64'h00);
        check("sat_add_e2", 64'(do_m[2]), 64'h7F);
        check("sat_add_e3", 64'(do_m[3]), 64'h80);
        check("sat_add_sat", 64'(sat_m), 64'd1);
        step();
        step();

        // Local valid alone never pushes in merge mode.
        set_m(rnd_vec(), rnd_vec());
        vl_m = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("lonely_ready_local", 64'(rl_m), 64'd0);
            check("lonely_valid_o", 64'(vo_m), 64'd0);
            step();
        end
        vm_m = 1'b1;
        #1;
        check("pair_ready_local", 64'(rl_m), 64'd1);
        check("pair_ready_mergein", 64'(rm_m), 64'd1);
        step();
        vl_m = 1'b0; vm_m = 1'b0;
        check("pair_valid_o", 64'(vo_m), 64'd1);
        step();

        // Backpressure: A,B stored, C held until space frees up.
        pulse_reset();
        ready_i = 1'b0;
        vl_m = 1'b1; vm_m = 1'b1;
        set_m(32'h01020304, 32'h01010101);
        step();
        set_m(32'h05060708, 32'h01010101);
        step();
        set_m(32'h090A0B0C, 32'h01010101);
        for (int c = 0; c < 3; c++) begin
            check("full_ready_local", 64'(rl_m), 64'd0);
            check("full_ready_mergein", 64'(rm_m), 64'd0);
            check("full_head_A", 64'(pack(do_m)), 64'h02030405);
            step();
        end
        ready_i = 1'b1;
        step();
        check("drain_head_B", 64'(pack(do_m)), 64'h06070809);
        step();
        vl_m = 1'b0; vm_m = 1'b0;
        check("drain_head_C", 64'(pack(do_m)), 64'h0A0B0C0D);
        step();
        check("drain_beats", 64'(cnt_m), 64'd3);
        check("drain_empty", 64'(vo_m), 64'd0);

        // Pass-through mode with merge-in valid toggling.
        for (int c = 0; c < 4; c++) begin
            set_p(rnd_vec(), rnd_vec());
            vl_p = 1'b1;
            vm_p = c[0];
            step();
        end
        vl_p = 1'b0; vm_p = 1'b0;
        step();
        step();
        check("pass_sat", 64'(sat_p), 64'd0);
        check("pass_beats", 64'(cnt_p), 64'd4);

        // Reset with two beats buffered.
        ready_i = 1'b0;
        vl_m = 1'b1; vm_m = 1'b1;
        set_m(32'h7F7F7F7F, 32'h7F7F7F7F);
        step();
        step();
        vl_m = 1'b0; vm_m = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_valid_now", 64'(vo_m), 64'd0);
        check("rst_beats", 64'(cnt_m), 64'd0);
        check("rst_sat", 64'(sat_m), 64'd0);
        step();
        rst = 1'b0;
        ready_i = 1'b1;
        set_m(32'h04030201, 32'h01010101);
        vl_m = 1'b1; vm_m = 1'b1;
        step();
        vl_m = 1'b0; vm_m = 1'b0;
        check("post_rst_first", 64'(pack(do_m)), 64'h05040302);
        step();

        // Randomized soak on both instances.
        for (int c = 0; c < 2000; c++) begin
            set_m(rnd_vec(), rnd_vec());
            set_p(rnd_vec(), rnd_vec());
            vl_m = 1'($urandom_range(0, 1));
            vm_m = 1'($urandom_range(0, 1));
            vl_p = 1'($urandom_range(0, 1));
            vm_p = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        vl_m = 1'b0; vm_m = 1'b0; vl_p = 1'b0; vm_p = 1'b0;
        ready_i = 1'b1;
        step();
        step();

        // Beat counter wrap on a continuous pass-through stream.
        pulse_reset();
        vl_p = 1'b1;
        begin
            int c;
            for (c = 0; c < 70000; c++) begin
                if (cnt_p == 16'hFFFF) break;
                step();
            end
            check("wrap_reached_ffff", 64'(cnt_p), 64'hFFFF);
        end
        check("wrap_valid", 64'(vo_p), 64'd1);
        step();
        check("wrap_zero", 64'(cnt_p), 64'd0);
        vl_p = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
